// File: rtl/udp_arb_pkg.sv
// Shared types for the UDP TX arbiter: FSM encoding, header field widths, packed header.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_t;

  localparam int DSCP_W = 6;
  localparam int ECN_W  = 2;
  localparam int TTL_W  = 8;
  localparam int IP_W   = 32;
  localparam int PORT_W = 16;
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 16;

  // 6+2+8+32+32+16+16+16+16 = 144
  localparam int UDP_HDR_WIDTH = DSCP_W + ECN_W + TTL_W + 2*IP_W + 2*PORT_W + LEN_W + CSUM_W;

  typedef struct packed {
    logic [DSCP_W-1:0] dscp;
    logic [ECN_W-1:0]  ecn;
    logic [TTL_W-1:0]  ttl;
    logic [IP_W-1:0]   src_ip;
    logic [IP_W-1:0]   dst_ip;
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] dst_port;
    logic [LEN_W-1:0]  length;
    logic [CSUM_W-1:0] checksum;
  } udp_hdr_t;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// N-lane UDP TX bus: header handshake + AXI-stream payload, fields packed lane-major.
// Latency: n/a (wires only).
// Backpressure: hdr_ready / payload_axis_tready flow from slave back to master.
// Modports: master drives header, valids and payload; slave drives hdr_ready and tready.
interface udp_tx_arbiter_if
  import udp_arb_pkg::*;
#(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [N-1:0]            hdr_valid;
  logic [N-1:0]            hdr_ready;
  logic [N*DSCP_W-1:0]     ip_dscp;
  logic [N*ECN_W-1:0]      ip_ecn;
  logic [N*TTL_W-1:0]      ip_ttl;
  logic [N*IP_W-1:0]       ip_source_ip;
  logic [N*IP_W-1:0]       ip_dest_ip;
  logic [N*PORT_W-1:0]     source_port;
  logic [N*PORT_W-1:0]     dest_port;
  logic [N*LEN_W-1:0]      length;
  logic [N*CSUM_W-1:0]     checksum;
  logic [N*DATA_WIDTH-1:0] payload_axis_tdata;
  logic [N*KEEP_WIDTH-1:0] payload_axis_tkeep;
  logic [N-1:0]            payload_axis_tvalid;
  logic [N-1:0]            payload_axis_tready;
  logic [N-1:0]            payload_axis_tlast;
  logic [N-1:0]            payload_axis_tuser;

  modport master (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
           payload_axis_tlast, payload_axis_tuser,
    input  hdr_ready, payload_axis_tready
  );

  modport slave (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
           payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
           payload_axis_tlast, payload_axis_tuser,
    output hdr_ready, payload_axis_tready
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first set request strictly after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
// Ports: req_i (PORTS), last_grant_i -> grant_o index, grant_valid_o (any request).
module rr_priority_encoder #(
  parameter int PORTS = 4,
  parameter int GW    = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [GW-1:0]    last_grant_i,
  output logic [GW-1:0]    grant_o,
  output logic             grant_valid_o
);
  int idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    // Offsets 1..PORTS so the last winner is considered last.
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last_grant_i) + i) % PORTS;
      if (!grant_valid_o && req_i[GW'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_o       = GW'(idx);
      end
    end
  end
endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UDP TX (header + payload) among PORTS requesters.
// Latency: header out 1 cycle after grant; payload is a combinational mux (0 cycles).
// Backpressure: m hdr_ready stalls in HDR; m tready passes straight to the granted port only.
// Ports: clk, rst (async active-high); s_udp (PORTS-lane slave), m_udp (1-lane master);
//        grant_port = current/last granted index; busy = FSM not idle.
// Option: UDP_TX_ARB_PRIO_EN makes port 0 strict priority, ports 1..PORTS-1 round-robin.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                     clk,
  input  logic                     rst,
  udp_tx_arbiter_if.slave          s_udp,
  udp_tx_arbiter_if.master         m_udp,
  output logic [$clog2(PORTS)-1:0] grant_port,
  output logic                     busy
);
  localparam int GW = $clog2(PORTS);

  arb_state_t     state_q;
  udp_hdr_t       hdr_q;
  logic           hdr_vld_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  last_grant_q;

  logic [PORTS-1:0] rr_req;
  logic [GW-1:0]    rr_gnt;
  logic             rr_vld;
  logic [GW-1:0]    arb_gnt;
  logic             arb_vld;
  udp_hdr_t         hdr_sel;
  int unsigned      hsel;
  int unsigned      psel;
  logic             in_payload;
  logic             beat_last;

`ifdef UDP_TX_ARB_PRIO_EN
  // Port 0 bypasses the rotation entirely; the encoder only sees ports 1..PORTS-1.
  assign rr_req  = {s_udp.hdr_valid[PORTS-1:1], 1'b0};
  assign arb_vld = s_udp.hdr_valid[0] | rr_vld;
  assign arb_gnt = s_udp.hdr_valid[0] ? '0 : rr_gnt;
`else
  assign rr_req  = s_udp.hdr_valid;
  assign arb_vld = rr_vld;
  assign arb_gnt = rr_gnt;
`endif

  rr_priority_encoder #(.PORTS(PORTS), .GW(GW)) u_rr (
    .req_i         (rr_req),
    .last_grant_i  (last_grant_q),
    .grant_o       (rr_gnt),
    .grant_valid_o (rr_vld)
  );

  assign hsel = 32'(arb_gnt);
  assign psel = 32'(grant_q);

  always_comb begin
    hdr_sel          = '0;
    hdr_sel.dscp     = s_udp.ip_dscp[hsel*DSCP_W +: DSCP_W];
    hdr_sel.ecn      = s_udp.ip_ecn[hsel*ECN_W +: ECN_W];
    hdr_sel.ttl      = s_udp.ip_ttl[hsel*TTL_W +: TTL_W];
    hdr_sel.src_ip   = s_udp.ip_source_ip[hsel*IP_W +: IP_W];
    hdr_sel.dst_ip   = s_udp.ip_dest_ip[hsel*IP_W +: IP_W];
    hdr_sel.src_port = s_udp.source_port[hsel*PORT_W +: PORT_W];
    hdr_sel.dst_port = s_udp.dest_port[hsel*PORT_W +: PORT_W];
    hdr_sel.length   = s_udp.length[hsel*LEN_W +: LEN_W];
    hdr_sel.checksum = s_udp.checksum[hsel*CSUM_W +: CSUM_W];
  end

  // Header accept is a one-cycle pulse in IDLE; gated by rst so a request
  // held across reset is never acknowledged while the FSM is being cleared.
  always_comb begin
    s_udp.hdr_ready = '0;
    if (!rst && state_q == ST_IDLE && arb_vld)
      s_udp.hdr_ready[arb_gnt] = 1'b1;
  end

  assign in_payload = (state_q == ST_PAYLOAD);

  assign m_udp.payload_axis_tdata  = s_udp.payload_axis_tdata[psel*DATA_WIDTH +: DATA_WIDTH];
  assign m_udp.payload_axis_tkeep  = s_udp.payload_axis_tkeep[psel*KEEP_WIDTH +: KEEP_WIDTH];
  assign m_udp.payload_axis_tvalid = in_payload & s_udp.payload_axis_tvalid[grant_q];
  assign m_udp.payload_axis_tlast  = s_udp.payload_axis_tlast[grant_q];
  assign m_udp.payload_axis_tuser  = s_udp.payload_axis_tuser[grant_q];

  always_comb begin
    s_udp.payload_axis_tready = '0;
    if (in_payload)
      s_udp.payload_axis_tready[grant_q] = m_udp.payload_axis_tready;
  end

  assign beat_last = m_udp.payload_axis_tvalid & m_udp.payload_axis_tready
                   & m_udp.payload_axis_tlast;

  assign m_udp.hdr_valid    = hdr_vld_q;
  assign m_udp.ip_dscp      = hdr_q.dscp;
  assign m_udp.ip_ecn       = hdr_q.ecn;
  assign m_udp.ip_ttl       = hdr_q.ttl;
  assign m_udp.ip_source_ip = hdr_q.src_ip;
  assign m_udp.ip_dest_ip   = hdr_q.dst_ip;
  assign m_udp.source_port  = hdr_q.src_port;
  assign m_udp.dest_port    = hdr_q.dst_port;
  assign m_udp.length       = hdr_q.length;
  assign m_udp.checksum     = hdr_q.checksum;

  assign grant_port = grant_q;
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      hdr_vld_q    <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= GW'(PORTS-1);  // port 0 wins the first arbitration
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            hdr_q     <= hdr_sel;
            grant_q   <= arb_gnt;
            hdr_vld_q <= 1'b1;
            state_q   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_udp.hdr_ready) begin
            hdr_vld_q <= 1'b0;
            state_q   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (beat_last) begin
            state_q <= ST_IDLE;
`ifdef UDP_TX_ARB_PRIO_EN
            // Priority grants leave the rotation of ports 1..PORTS-1 untouched.
            if (grant_q != '0)
              last_grant_q <= grant_q;
`else
            last_grant_q <= grant_q;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (4 ports, 64-bit payload).
// Latency: n/a.
// Backpressure: exercised via held hdr_ready and toggled tready.
module tb_udp_tx_arbiter;
  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_port;
  logic       busy;

  udp_tx_arbiter_if #(.N(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_udp ();
  udp_tx_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_udp ();

  udp_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_udp      (s_udp),
    .m_udp      (m_udp),
    .grant_port (grant_port),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int p, input int f, input int b);
    return {8'(p), 8'(f), 8'(b), 40'hA5A55A5A3C};
  endfunction

  function automatic logic [7:0] mk_keep(input bit last);
    return last ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic [143:0] exp_hdr(input int p, input logic [31:0] dip,
                                           input logic [15:0] dport, input logic [15:0] len);
    return {6'(p+1), 2'(p), 8'(64+p), 32'h0A000000 + 32'(p), dip,
            16'(5000+p), dport, len, 16'(p*4369)};
  endfunction

  function automatic logic [143:0] dut_hdr();
    return {m_udp.ip_dscp, m_udp.ip_ecn, m_udp.ip_ttl, m_udp.ip_source_ip, m_udp.ip_dest_ip,
            m_udp.source_port, m_udp.dest_port, m_udp.length, m_udp.checksum};
  endfunction

  task automatic set_hdr(input int p, input logic [31:0] dip, input logic [15:0] dport,
                         input logic [15:0] len);
    s_udp.ip_dscp[p*6 +: 6]        = 6'(p+1);
    s_udp.ip_ecn[p*2 +: 2]         = 2'(p);
    s_udp.ip_ttl[p*8 +: 8]         = 8'(64+p);
    s_udp.ip_source_ip[p*32 +: 32] = 32'h0A000000 + 32'(p);
    s_udp.ip_dest_ip[p*32 +: 32]   = dip;
    s_udp.source_port[p*16 +: 16]  = 16'(5000+p);
    s_udp.dest_port[p*16 +: 16]    = dport;
    s_udp.length[p*16 +: 16]       = len;
    s_udp.checksum[p*16 +: 16]     = 16'(p*4369);
  endtask

  task automatic clear_inputs();
    s_udp.hdr_valid           = '0;
    s_udp.ip_dscp             = '0;
    s_udp.ip_ecn              = '0;
    s_udp.ip_ttl              = '0;
    s_udp.ip_source_ip        = '0;
    s_udp.ip_dest_ip          = '0;
    s_udp.source_port         = '0;
    s_udp.dest_port           = '0;
    s_udp.length              = '0;
    s_udp.checksum            = '0;
    s_udp.payload_axis_tdata  = '0;
    s_udp.payload_axis_tkeep  = '0;
    s_udp.payload_axis_tvalid = '0;
    s_udp.payload_axis_tlast  = '0;
    s_udp.payload_axis_tuser  = '0;
    m_udp.hdr_ready           = 1'b1;
    m_udp.payload_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Source/sink model shared by the multi-frame scenarios.
  int frames_left [P];
  int exp_ord [$];

  task automatic run_frames(input int nb, input int hold, input bit toggle, input int budget);
    int beats_left [P];
    int fr_src [P];
    int out_fr [P];
    bit hdr_pend [P];
    int ngr = 0, nbeats = 0, cur = -1, cur_fr = 0, bcnt = 0, wait_cyc = 0;
    int exp_n = exp_ord.size();
    int b;
    logic [P-1:0] hs_h, hs_b, mask;
    for (int p = 0; p < P; p++) begin
      beats_left[p] = 0;
      fr_src[p]     = 0;
      out_fr[p]     = 0;
      hdr_pend[p]   = (frames_left[p] > 0);
      if (hdr_pend[p]) frames_left[p]--;
    end
    for (int cyc = 0; cyc < budget && nbeats < exp_n*nb; cyc++) begin
      m_udp.hdr_ready           = (cyc >= hold);
      m_udp.payload_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      for (int p = 0; p < P; p++) begin
        b = nb - beats_left[p];
        set_hdr(p, 32'hC0A80100 + 32'(p), 16'(1000+p), 16'(16+8*p));
        s_udp.hdr_valid[p]                = hdr_pend[p];
        s_udp.payload_axis_tvalid[p]      = (beats_left[p] > 0);
        s_udp.payload_axis_tdata[p*64 +: 64] = mk_data(p, fr_src[p], b);
        s_udp.payload_axis_tkeep[p*8 +: 8]   = mk_keep(b == nb-1);
        s_udp.payload_axis_tlast[p]       = (beats_left[p] == 1);
        s_udp.payload_axis_tuser[p]       = ((b % 2) == 1);
      end
      @(negedge clk);
      if (m_udp.hdr_valid[0]) begin
        if (ngr < exp_n)
          check("hdr_fields", dut_hdr(),
                exp_hdr(exp_ord[ngr], 32'hC0A80100 + 32'(exp_ord[ngr]),
                        16'(1000+exp_ord[ngr]), 16'(16+8*exp_ord[ngr])));
        else
          check("grant_count", ngr+1, exp_n);
        check("no_beat_in_hdr", m_udp.payload_axis_tvalid, 0);
        if (!m_udp.hdr_ready[0]) wait_cyc++;
        else if (ngr < exp_n) begin
          cur    = exp_ord[ngr];
          cur_fr = out_fr[cur];
          out_fr[cur]++;
          bcnt = 0;
          ngr++;
        end
      end
      if (m_udp.payload_axis_tvalid[0] && m_udp.payload_axis_tready[0]) begin
        check("beat", {m_udp.payload_axis_tdata, m_udp.payload_axis_tkeep,
                       m_udp.payload_axis_tlast, m_udp.payload_axis_tuser},
              {mk_data(cur, cur_fr, bcnt), mk_keep(bcnt == nb-1), bcnt == nb-1, (bcnt % 2) == 1});
        bcnt++;
        nbeats++;
      end
      mask = (cur >= 0) ? P'(1 << cur) : '0;
      check("tready_iso", s_udp.payload_axis_tready & ~mask, 0);
      hs_h = s_udp.hdr_valid & s_udp.hdr_ready;
      hs_b = s_udp.payload_axis_tvalid & s_udp.payload_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < P; p++) begin
        if (hs_h[p]) begin
          hdr_pend[p]   = 1'b0;
          beats_left[p] = nb;
        end
        if (hs_b[p]) begin
          beats_left[p]--;
          if (beats_left[p] == 0) begin
            fr_src[p]++;
            if (frames_left[p] > 0) begin
              frames_left[p]--;
              hdr_pend[p] = 1'b1;
            end
          end
        end
      end
    end
    check("frames", ngr, exp_n);
    check("beats", nbeats, exp_n*nb);
    check("idle_after", busy, 0);
    if (hold > 0) check("hdr_wait_cycles", wait_cyc, hold-1);
  endtask

  initial begin
    // Reset state, including a request held during reset.
    rst = 1'b1;
    clear_inputs();
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_port, 0);
    check("rst_m_hdr_valid", m_udp.hdr_valid, 0);
    check("rst_m_tvalid", m_udp.payload_axis_tvalid, 0);
    check("rst_hdr_fields", dut_hdr(), 0);
    s_udp.hdr_valid = 4'b1111;
    #1;
    check("rst_s_hdr_ready", s_udp.hdr_ready, 0);
    check("rst_s_tready", s_udp.payload_axis_tready, 0);
    do_reset();

    // Port 2 alone, single-beat frame.
    set_hdr(2, 32'hC0A8010A, 16'd1234, 16'd16);
    s_udp.hdr_valid              = 4'b0100;
    s_udp.payload_axis_tvalid[2] = 1'b1;
    s_udp.payload_axis_tdata[128 +: 64] = mk_data(2, 0, 0);
    s_udp.payload_axis_tkeep[16 +: 8]   = 8'hFF;
    s_udp.payload_axis_tlast[2]  = 1'b1;
    s_udp.payload_axis_tuser[2]  = 1'b1;
    #1;
    check("p2_hdr_ready_pulse", s_udp.hdr_ready, 4'b0100);
    check("p2_m_valid_c0", m_udp.hdr_valid, 0);
    @(posedge clk); #1;
    s_udp.hdr_valid = '0;
    check("p2_m_valid_c1", m_udp.hdr_valid, 1);
    check("p2_hdr", dut_hdr(), exp_hdr(2, 32'hC0A8010A, 16'd1234, 16'd16));
    check("p2_grant", grant_port, 2);
    check("p2_busy", busy, 1);
    check("p2_no_beat_hdr", m_udp.payload_axis_tvalid, 0);
    check("p2_hdr_ready_drop", s_udp.hdr_ready, 0);
    @(posedge clk); #1;
    check("p2_m_valid_c2", m_udp.hdr_valid, 0);
    check("p2_beat", {m_udp.payload_axis_tvalid, m_udp.payload_axis_tdata,
                      m_udp.payload_axis_tkeep, m_udp.payload_axis_tlast, m_udp.payload_axis_tuser},
          {1'b1, mk_data(2, 0, 0), 8'hFF, 1'b1, 1'b1});
    check("p2_tready", s_udp.payload_axis_tready, 4'b0100);
    @(posedge clk); #1;
    s_udp.payload_axis_tvalid = '0;
    check("p2_idle_c3", busy, 0);
    do_reset();

    // All ports, 2 frames each of 3 beats: strict rotation.
    frames_left = '{2, 2, 2, 2};
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_frames(3, 0, 1'b0, 400);
    do_reset();

    // Header stalled 10 cycles.
    frames_left = '{0, 1, 0, 0};
    exp_ord = '{1};
    run_frames(2, 11, 1'b0, 100);
    do_reset();

    // tready toggling during a 4-beat frame from port 1.
    frames_left = '{0, 1, 0, 0};
    exp_ord = '{1};
    run_frames(4, 0, 1'b1, 100);
    do_reset();

    // Async reset in the middle of a 4-beat frame from port 3.
    set_hdr(3, 32'hC0A80103, 16'd1003, 16'd40);
    s_udp.hdr_valid              = 4'b1000;
    s_udp.payload_axis_tvalid[3] = 1'b1;
    s_udp.payload_axis_tdata[192 +: 64] = mk_data(3, 0, 0);
    @(posedge clk); #1;
    s_udp.hdr_valid = '0;
    @(posedge clk); #1;
    check("mr_beat0_valid", m_udp.payload_axis_tvalid, 1);
    @(posedge clk); #1;
    s_udp.payload_axis_tdata[192 +: 64] = mk_data(3, 0, 1);
    set_hdr(0, 32'hC0A80100, 16'd1000, 16'd16);
    s_udp.hdr_valid = 4'b1001;
    check("mr_beat1_valid", m_udp.payload_axis_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_tvalid_drop", m_udp.payload_axis_tvalid, 0);
    check("mr_tready_drop", s_udp.payload_axis_tready, 0);
    check("mr_busy_drop", busy, 0);
    check("mr_hdr_ready_in_rst", s_udp.hdr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mr_port0_first", s_udp.hdr_ready, 4'b0001);
    @(posedge clk); #1;
    check("mr_grant0", grant_port, 0);
    check("mr_hdr0", dut_hdr(), exp_hdr(0, 32'hC0A80100, 16'd1000, 16'd16));
    do_reset();

    // Ports 0 and 3 competing.
    frames_left = '{3, 0, 0, 1};
`ifdef UDP_TX_ARB_PRIO_EN
    exp_ord = '{0, 0, 0, 3};
`else
    exp_ord = '{0, 3, 0, 0};
`endif
    run_frames(2, 0, 1'b0, 200);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit interface (s_udp_* header + 64-bit payload) of the UDP/IP stack among PORTS independent requesters.
- Grants are round-robin and frame-atomic: one header plus its complete payload frame per grant.
- Sits between user application ports and the stack's UDP frame input.
- The output side drives the stack's s_udp_* signals directly.

Parameters:
- PORTS, 4, number of requesters (2..8).
- DATA_WIDTH, 64, payload tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, payload tkeep width.

Ports:
- clk  in  1  system clock (156.25 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- s_udp_hdr_valid  in  PORTS  per-port header valid.
- s_udp_hdr_ready  out  PORTS  per-port header accept.
- s_udp_ip_dscp  in  PORTS*6  per-port DSCP.
- s_udp_ip_ecn  in  PORTS*2  per-port ECN.
- s_udp_ip_ttl  in  PORTS*8  per-port TTL.
- s_udp_ip_source_ip  in  PORTS*32  per-port source IP.
- s_udp_ip_dest_ip  in  PORTS*32  per-port destination IP.
- s_udp_source_port  in  PORTS*16  per-port source port.
- s_udp_dest_port  in  PORTS*16  per-port destination port.
- s_udp_length  in  PORTS*16  per-port UDP length.
- s_udp_checksum  in  PORTS*16  per-port UDP checksum.
- s_udp_payload_axis_tdata  in  PORTS*DATA_WIDTH  per-port payload data.
- s_udp_payload_axis_tkeep  in  PORTS*KEEP_WIDTH  per-port byte enables.
- s_udp_payload_axis_tvalid  in  PORTS  per-port payload valid.
- s_udp_payload_axis_tready  out  PORTS  per-port payload ready.
- s_udp_payload_axis_tlast  in  PORTS  per-port end of frame.
- s_udp_payload_axis_tuser  in  PORTS  per-port frame error flag.
- m_udp_* (hdr_valid out 1, hdr_ready in 1, ip_dscp 6, ip_ecn 2, ip_ttl 8, ip_source_ip 32, ip_dest_ip 32, source_port 16, dest_port 16, length 16, checksum 16, payload_axis_tdata DATA_WIDTH, tkeep KEEP_WIDTH, tvalid 1, tready in 1, tlast 1, tuser 1)  shared output to the stack.
- grant_port  out  $clog2(PORTS)  index of the current or last granted port.
- busy  out  1  high while the state is not IDLE.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - state = IDLE; all s_*_ready = 0; m_udp_hdr_valid = 0; m_udp_payload_axis_tvalid = 0.
  - Header registers = 0; grant_port = 0.
  - Round-robin pointer last_grant = PORTS-1, so port 0 wins first.
- State machine: IDLE -> HDR -> PAYLOAD -> IDLE.
- IDLE:
  - If any s_udp_hdr_valid bit is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo PORTS.
  - In that cycle, pulse s_udp_hdr_ready[g] for one cycle and register all header fields of port g into the m_udp_* header registers.
  - Set grant_port = g and go to HDR. m_udp_hdr_valid = 1 from the next cycle (1-cycle header latency).
- HDR:
  - Hold the header registers stable and keep m_udp_hdr_valid high until m_udp_hdr_ready = 1.
  - On that handshake, deassert m_udp_hdr_valid on the next edge and go to PAYLOAD.
  - No payload passes while in HDR.
- PAYLOAD:
  - Combinational mux: m_udp_payload_* = port g's payload; s_udp_payload_axis_tready[g] = m_udp_payload_axis_tready. All other tready bits = 0.
  - A beat with tvalid && tready && tlast ends the frame: last_grant <= g and go to IDLE.
  - tuser passes through unmodified.
- Throughput: minimum 2 cycles of arbitration overhead per frame (IDLE + header handshake). A single-beat frame occupies >= 3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Requests from other ports remain pending and are never dropped.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,3,0,... exactly.
- A requester that deasserts hdr_valid while ungranted is simply not considered.
- Ungranted ports always see hdr_ready = 0 and tready = 0.
- Reset mid-frame: the output frame is abandoned without tlast. Downstream reset is required alongside, since the stack shares rst.
- A zero-length payload is not supported: every grant expects at least one beat ending in tlast.

Optional Feature:
- UDP_TX_ARB_PRIO_EN defined:
  - Port 0 is strict high priority. If s_udp_hdr_valid[0] is set in IDLE, port 0 wins regardless of last_grant.
  - Ports 1..PORTS-1 share round-robin among themselves; the port-0 grant does not update last_grant.
- Undefined: pure round-robin across all ports, as above.

Decomposition:
- Shared package udp_arb_pkg:
  - state encoding constants (ST_IDLE, ST_HDR, ST_PAYLOAD);
  - header field width constants;
  - UDP_HDR_WIDTH (total packed header width, 144 bits).
- One natural sub-module: rr_priority_encoder (PORTS-wide request vector + last_grant -> grant index and grant_valid). It is purely combinational and reusable by later RX/stream arbiters.

Test Plan:
- Port 2 alone sends header (dest_ip 192.168.1.10, dest_port 1234, length 16) plus 1-beat payload, with m_udp_hdr_ready and tready tied high -> s_udp_hdr_ready[2] pulses 1 cycle; m_udp_hdr_valid rises the next cycle with identical fields; 1 payload beat; busy low 3 cycles after the request.
- All 4 ports request continuously, each with 3-beat frames -> grant order 0,1,2,3,0,1; no interleaving of beats between frames.
- m_udp_hdr_ready held low 10 cycles -> header fields stable and m_udp_hdr_valid held; zero payload beats pass; resumes correctly when ready rises.
- m_udp_payload_axis_tready toggles 1,0,1,0 during a 4-beat frame from port 1 -> exactly 4 beats transferred; tdata/tkeep/tuser match the source; other ports' tready stay 0.
- rst asserted asynchronously mid-PAYLOAD (beat 2 of 4) -> outputs drop immediately without a clock; after release, port 0 wins first.
- With UDP_TX_ARB_PRIO_EN: ports 0 and 3 request repeatedly -> port 0 granted every arbitration until idle, then port 3.
